// File: rtl/params_pkg.sv
// rtl/params_pkg.sv - shared core widths and the instruction word type
package params_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  typedef logic [DATA_WIDTH-1:0] instruction_t;
endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response and decode-side bundle of the fetch stage
interface fetch_stage_if #(
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH
);
  logic                  imem_req_o;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic                  imem_rvalid_i;
  logic [DATA_WIDTH-1:0] imem_rdata_i;
  logic                  valid_o;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic [DATA_WIDTH-1:0] instruction_o;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_rvalid_i,
    input  imem_rdata_i,
    output valid_o,
    output pc_o,
    output instruction_o
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_rvalid_i,
    output imem_rdata_i,
    input  valid_o,
    input  pc_o,
    input  instruction_o
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - single-outstanding instruction fetch with decode hold and ALU redirect
module fetch_stage #(
  parameter int                  DATA_WIDTH = params_pkg::DATA_WIDTH,
  parameter int                  ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  is_jump_i,
  input  logic                  branch_taken_i,
  input  logic [ADDR_WIDTH-1:0] jump_target_i,
  fetch_stage_if.master         bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  drop_q, drop_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  req;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] tgt;
  logic                  unused_tgt_low;

  assign redirect       = is_jump_i | branch_taken_i;
  assign tgt            = {jump_target_i[ADDR_WIDTH-1:2], 2'b00};
  assign unused_tgt_low = ^jump_target_i[1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      drop_q   <= 1'b0;
      valid_q  <= 1'b0;
      pc_out_q <= '0;
      instr_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      drop_q   <= drop_d;
      valid_q  <= valid_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
    end
  end

  // Redirect always wins: over stall in HOLD and over capturing a response in WAIT.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    valid_d  = valid_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    req      = 1'b0;
    unique case (state_q)
      FETCH: begin
        req     = 1'b1;
        state_d = WAIT;
        if (redirect) begin
          // The request for the old PC is already out; its response must be thrown away.
          pc_d   = tgt;
          drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid_i) begin
          if (!drop_q && !redirect) begin
            instr_d  = bus.imem_rdata_i;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + ADDR_WIDTH'(4);
            state_d  = HOLD;
          end else begin
            drop_d  = 1'b0;
            state_d = FETCH;
            if (redirect) begin
              pc_d = tgt;
            end
          end
        end else if (redirect) begin
          pc_d   = tgt;
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = tgt;
          state_d = FETCH;
        end else if (!stall_i) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign bus.imem_req_o    = req & rst_i;
  assign bus.imem_addr_o   = pc_q;
  assign bus.valid_o       = valid_q;
  assign bus.pc_o          = pc_out_q;
  assign bus.instruction_o = instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - latency-programmable imem model with presentation scoreboard for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        is_jump;
  logic        branch_taken;
  logic [31:0] jump_target;

  always #5 clk = ~clk;

  fetch_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  fetch_stage #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .RESET_PC  (32'h0)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .is_jump_i     (is_jump),
    .branch_taken_i(branch_taken),
    .jump_target_i (jump_target),
    .bus           (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } pres_t;

  typedef struct {
    int          lat;
    int          stall_n;
    logic [31:0] addr;
    logic [31:0] instr;
  } vec_t;

  pres_t       exp_q[$];
  vec_t        tbl[5];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          pend = 0;
  bit          taint = 0;
  int          wcnt = 0;
  logic [31:0] paddr = '0;
  logic [31:0] resp_addr = '0;
  logic        prev_valid = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Close out the current cycle (memory sees req, redirect taints outstanding), advance, open the next.
  task automatic tick();
    pres_t e;
    #1;
    if (!rst) begin
      pend  = 0;
      taint = 0;
    end else begin
      if (bus.imem_rvalid_i) begin
        if (!taint && !(is_jump | branch_taken))
          exp_q.push_back('{pc: resp_addr, instr: bus.imem_rdata_i});
        taint = 0;
      end
      if (bus.imem_req_o) begin
        check("single_outstanding", 64'(pend), 64'd0);
        check("no_req_while_valid", 64'(bus.valid_o), 64'd0);
        pend  = 1;
        wcnt  = lat;
        paddr = bus.imem_addr_o;
      end
      if ((is_jump | branch_taken) && pend) taint = 1;
    end
    prev_valid = bus.valid_o;
    @(posedge clk);
    #1;
    cyc++;
    bus.imem_rvalid_i = 1'b0;
    if (pend) begin
      wcnt--;
      if (wcnt == 0) begin
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = mem_word(paddr);
        resp_addr         = paddr;
        pend              = 0;
      end
    end
    if (bus.valid_o && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_present: pc=%0h instr=%0h required no presentation (cycle %0d)",
                 bus.pc_o, bus.instruction_o, cyc);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", 64'(bus.pc_o), 64'(e.pc));
        check("sb_instr", 64'(bus.instruction_o), 64'(e.instr));
      end
    end
  endtask

  task automatic wait_req(output int n, input int budget);
    n = 0;
    #1;
    while (!bus.imem_req_o && n < budget) begin
      tick();
      n++;
    end
    if (!bus.imem_req_o) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_req_timeout: no request within %0d cycles (cycle %0d)", budget, cyc);
    end
  endtask

  task automatic wait_valid(output int n, input int budget);
    n = 0;
    #1;
    while (!bus.valid_o && n < budget) begin
      tick();
      n++;
    end
    if (!bus.valid_o) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_valid_timeout: valid_o low for %0d cycles (cycle %0d)", budget, cyc);
    end
  endtask

  initial begin
    int          n;
    int          req_cyc;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    tbl[0] = '{lat: 1, stall_n: 0, addr: 32'h04, instr: 32'h0};
    tbl[1] = '{lat: 2, stall_n: 3, addr: 32'h08, instr: 32'h0};
    tbl[2] = '{lat: 3, stall_n: 0, addr: 32'h0C, instr: 32'h0};
    tbl[3] = '{lat: 1, stall_n: 5, addr: 32'h10, instr: 32'h0};
    tbl[4] = '{lat: 4, stall_n: 1, addr: 32'h14, instr: 32'h0};
    for (int i = 0; i < 5; i++) tbl[i].instr = mem_word(tbl[i].addr);

    rst = 1'b0; stall = 1'b0; is_jump = 1'b0; branch_taken = 1'b0; jump_target = '0;
    bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;

    // Reset two cycles, then first fetch from 0 with L=1
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_valid", 64'(bus.valid_o), 64'd0);
      check("rst_req", 64'(bus.imem_req_o), 64'd0);
      check("rst_pc", 64'(bus.pc_o), 64'd0);
      check("rst_instr", 64'(bus.instruction_o), 64'd0);
    end
    rst = 1'b1;
    lat = 1;
    #1;
    check("first_req", 64'(bus.imem_req_o), 64'd1);
    check("first_addr", 64'(bus.imem_addr_o), 64'd0);
    req_cyc = cyc;
    wait_valid(n, 20);
    check("first_latency", 64'(cyc - req_cyc), 64'd2);
    check("first_pc", 64'(bus.pc_o), 64'd0);
    check("first_instr", 64'(bus.instruction_o), 64'h00500093);

    // Sequential fetches with varying latency and decode stall
    for (int i = 0; i < 5; i++) begin
      lat   = tbl[i].lat;
      stall = 1'b0;
      wait_req(n, 10);
      check("req_gap", 64'(n), 64'd1);
      check("req_addr", 64'(bus.imem_addr_o), 64'(tbl[i].addr));
      req_cyc = cyc;
      stall   = (tbl[i].stall_n > 0);
      wait_valid(n, 20);
      check("fetch_latency", 64'(cyc - req_cyc), 64'(tbl[i].lat + 1));
      check("vec_pc", 64'(bus.pc_o), 64'(tbl[i].addr));
      check("vec_instr", 64'(bus.instruction_o), 64'(tbl[i].instr));
      hold_pc    = bus.pc_o;
      hold_instr = bus.instruction_o;
      for (int k = 0; k < tbl[i].stall_n; k++) begin
        tick();
        check("stall_valid", 64'(bus.valid_o), 64'd1);
        check("stall_pc", 64'(bus.pc_o), 64'(hold_pc));
        check("stall_instr", 64'(bus.instruction_o), 64'(hold_instr));
        check("stall_no_req", 64'(bus.imem_req_o), 64'd0);
      end
      stall = 1'b0;
    end

    // Taken branch one cycle after the request, L=4: response dropped, refetch at 0x40
    lat = 4;
    wait_req(n, 10);
    check("wait_redir_old_addr", 64'(bus.imem_addr_o), 64'h18);
    req_cyc = cyc;
    tick();
    branch_taken = 1'b1;
    jump_target  = 32'h40;
    tick();
    branch_taken = 1'b0;
    wait_req(n, 10);
    check("wait_redir_valid", 64'(bus.valid_o), 64'd0);
    check("wait_redir_addr", 64'(bus.imem_addr_o), 64'h40);
    check("wait_redir_latency", 64'(cyc - req_cyc), 64'd5);
    wait_valid(n, 20);
    check("wait_redir_pc", 64'(bus.pc_o), 64'h40);

    // Jump in HOLD while decode stalls; target low bits ignored
    stall = 1'b1;
    tick();
    tick();
    is_jump     = 1'b1;
    jump_target = 32'h103;
    tick();
    is_jump = 1'b0;
    stall   = 1'b0;
    check("hold_redir_valid", 64'(bus.valid_o), 64'd0);
    check("hold_redir_req", 64'(bus.imem_req_o), 64'd1);
    check("hold_redir_addr", 64'(bus.imem_addr_o), 64'h100);

    // Redirect (jump and branch together) in the same cycle as rvalid
    for (int k = 0; k < 4; k++) tick();
    check("coinc_rvalid", 64'(bus.imem_rvalid_i), 64'd1);
    is_jump      = 1'b1;
    branch_taken = 1'b1;
    jump_target  = 32'h200;
    lat          = 1;
    tick();
    is_jump      = 1'b0;
    branch_taken = 1'b0;
    check("coinc_valid", 64'(bus.valid_o), 64'd0);
    check("coinc_req", 64'(bus.imem_req_o), 64'd1);
    check("coinc_addr", 64'(bus.imem_addr_o), 64'h200);
    wait_valid(n, 20);
    check("coinc_pc", 64'(bus.pc_o), 64'h200);

    // PC wrap from the top of the address space
    is_jump     = 1'b1;
    jump_target = 32'hFFFF_FFFC;
    tick();
    is_jump = 1'b0;
    check("wrap_first_addr", 64'(bus.imem_addr_o), 64'hFFFF_FFFC);
    wait_valid(n, 20);
    check("wrap_pc", 64'(bus.pc_o), 64'hFFFF_FFFC);
    wait_req(n, 10);
    check("wrap_next_addr", 64'(bus.imem_addr_o), 64'h0);

    // Reset while a request is outstanding
    lat = 5;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("midrst_valid", 64'(bus.valid_o), 64'd0);
      check("midrst_req", 64'(bus.imem_req_o), 64'd0);
    end
    rst = 1'b1;
    lat = 1;
    #1;
    check("midrst_restart_req", 64'(bus.imem_req_o), 64'd1);
    check("midrst_restart_addr", 64'(bus.imem_addr_o), 64'h0);
    wait_valid(n, 20);
    check("midrst_pc", 64'(bus.pc_o), 64'h0);
    check("midrst_instr", 64'(bus.instruction_o), 64'h00500093);
    for (int k = 0; k < 3; k++) tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
